// File: rtl/clk_toggle_gen_pkg.sv
// -----------------------------------------------------------------------------
// clk_toggle_gen_pkg
// Shared types and default widths for the clk_toggle_gen block.
//   state_t    : generator FSM states (IDLE, RUN, STOPPING)
//   DIV_W_DEF  : default width of the half-period divider value
//   CNT_W_DEF  : default width of the rising-edge counter
// -----------------------------------------------------------------------------
package clk_toggle_gen_pkg;

  localparam int DIV_W_DEF = 16;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

endpackage : clk_toggle_gen_pkg

// File: rtl/clk_toggle_gen_if.sv
// -----------------------------------------------------------------------------
// clk_toggle_gen_if
// Control/status bundle of the clock toggle generator.
//   en          : level request to run the generated clock
//   half_period : clk cycles per generated half-period (0 behaves as 1)
//   clk_out     : generated toggling signal
//   running     : generator is not idle
//   edge_stb    : one-cycle pulse when clk_out rises
//   edge_cnt    : number of clk_out rising edges since reset
// Modports: master drives the request side, slave is the generator.
// -----------------------------------------------------------------------------
interface clk_toggle_gen_if
  import clk_toggle_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             en;
  logic [DIV_W-1:0] half_period;
  logic             clk_out;
  logic             running;
  logic             edge_stb;
  logic [CNT_W-1:0] edge_cnt;

  modport master (
    output en, half_period,
    input  clk_out, running, edge_stb, edge_cnt
  );

  modport slave (
    input  en, half_period,
    output clk_out, running, edge_stb, edge_cnt
  );

endinterface : clk_toggle_gen_if

// File: rtl/clk_toggle_div.sv
// -----------------------------------------------------------------------------
// clk_toggle_div
// Half-period divider for clk_toggle_gen. Holds the cycle counter and the
// latched half-period (hp_r), and flags the cycle on which clk_out must flip.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : generator leaving IDLE this edge (latch half_period)
//   active       : generator in RUN or STOPPING (divider counts)
//   clk_high     : current clk_out level (a 1->0 flip re-latches half_period)
//   half_period  : requested half-period, 0 substituted by 1
//   toggle       : clk_out flips on the next edge
// -----------------------------------------------------------------------------
module clk_toggle_div
  import clk_toggle_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             active,
  input  logic             clk_high,
  input  logic [DIV_W-1:0] half_period,
  output logic             toggle
);

  localparam logic [DIV_W-1:0] HP_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  // A zero half-period would never terminate; run it as one cycle instead.
  function automatic logic [DIV_W-1:0] sat_hp(input logic [DIV_W-1:0] hp);
    if (hp == {DIV_W{1'b0}}) begin
      return HP_ONE;
    end else begin
      return hp;
    end
  endfunction

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] hp_r;
  logic             toggle_s;

  // Terminal count of the current half-period (hp_r is never 0).
  always_comb begin
    toggle_s = 1'b0;
    if (active && (div_r == (hp_r - HP_ONE))) begin
      toggle_s = 1'b1;
    end else begin
      toggle_s = 1'b0;
    end
  end

  assign toggle = toggle_s;

  // Divider counter and half-period latch; hp_r only changes at start or
  // at the end of a high phase so a running phase is never resized.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_r <= {DIV_W{1'b0}};
      hp_r  <= HP_ONE;
    end else if (start) begin
      div_r <= {DIV_W{1'b0}};
      hp_r  <= sat_hp(half_period);
    end else if (active) begin
      if (toggle_s) begin
        div_r <= {DIV_W{1'b0}};
        if (clk_high) begin
          hp_r <= sat_hp(half_period);
        end else begin
          hp_r <= hp_r;
        end
      end else begin
        div_r <= div_r + HP_ONE;
        hp_r  <= hp_r;
      end
    end else begin
      div_r <= {DIV_W{1'b0}};
      hp_r  <= hp_r;
    end
  end

endmodule : clk_toggle_div

// File: rtl/clk_toggle_gen.sv
// -----------------------------------------------------------------------------
// clk_toggle_gen
// Generates a 50% duty toggling signal of period 2*half_period clk cycles
// while en is high, and stops cleanly at the end of a high phase.
// Ports:
//   clk    : sole clock, rising edge
//   rst_n  : synchronous active-low reset (overrides en)
//   bus    : clk_toggle_gen_if.slave (en, half_period in;
//            clk_out, running, edge_stb, edge_cnt out)
// Configuration: define CLK_TOGGLE_GEN_COUNT_EN to implement the rising-edge
// counter; otherwise edge_cnt is tied to 0.
// -----------------------------------------------------------------------------
module clk_toggle_gen
  import clk_toggle_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  clk_toggle_gen_if.slave  bus
);

  state_t state_r;
  logic   clk_out_r;
  logic   running_r;
  logic   edge_stb_r;
  logic   toggle_s;
  logic   start_s;
  logic   active_s;
  logic   rise_s;

  assign start_s  = (state_r == IDLE) & bus.en;
  assign active_s = (state_r != IDLE);

  clk_toggle_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_s),
    .active      (active_s),
    .clk_high    (clk_out_r),
    .half_period (bus.half_period),
    .toggle      (toggle_s)
  );

  // clk_out is about to go 0->1 on this edge. STOPPING only allows a rise
  // when en has come back, so a stop never produces an extra edge.
  always_comb begin
    rise_s = 1'b0;
    case (state_r)
      IDLE:     rise_s = bus.en;
      RUN:      rise_s = toggle_s & ~clk_out_r;
      STOPPING: rise_s = bus.en & toggle_s & ~clk_out_r;
      default:  rise_s = 1'b0;
    endcase
  end

  // Generator FSM with registered clk_out, running and edge_stb.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      clk_out_r  <= 1'b0;
      running_r  <= 1'b0;
      edge_stb_r <= 1'b0;
    end else begin
      edge_stb_r <= rise_s;
      case (state_r)
        IDLE: begin
          if (bus.en) begin
            state_r   <= RUN;
            clk_out_r <= 1'b1;
            running_r <= 1'b1;
          end else begin
            state_r   <= IDLE;
            clk_out_r <= 1'b0;
            running_r <= 1'b0;
          end
        end
        RUN: begin
          clk_out_r <= toggle_s ? ~clk_out_r : clk_out_r;
          running_r <= 1'b1;
          if (!bus.en) begin
            state_r <= STOPPING;
          end else begin
            state_r <= RUN;
          end
        end
        STOPPING: begin
          if (bus.en) begin
            // Resume without touching the phase in progress.
            state_r   <= RUN;
            clk_out_r <= toggle_s ? ~clk_out_r : clk_out_r;
            running_r <= 1'b1;
          end else if (toggle_s) begin
            // End of a phase: a high phase falls, a low phase stays low.
            state_r   <= IDLE;
            clk_out_r <= 1'b0;
            running_r <= 1'b0;
          end else begin
            state_r   <= STOPPING;
            clk_out_r <= clk_out_r;
            running_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          clk_out_r <= 1'b0;
          running_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clk_out  = clk_out_r;
  assign bus.running  = running_r;
  assign bus.edge_stb = edge_stb_r;

`ifdef CLK_TOGGLE_GEN_COUNT_EN
  logic [CNT_W-1:0] edge_cnt_r;

  // Rising-edge counter, wraps from all-ones to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      edge_cnt_r <= {CNT_W{1'b0}};
    end else if (rise_s) begin
      edge_cnt_r <= edge_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      edge_cnt_r <= edge_cnt_r;
    end
  end

  assign bus.edge_cnt = edge_cnt_r;
`else
  assign bus.edge_cnt = {CNT_W{1'b0}};
`endif

endmodule : clk_toggle_gen

// File: tb/tb_clk_toggle_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_toggle_gen
// Directed scenarios push the expected clk_out transitions into a queue; a
// monitor measures each phase at the falling clk edge and pops/compares on
// every clk_out transition. edge_stb is also checked every cycle against
// the observed rise of clk_out.
// -----------------------------------------------------------------------------
module tb_clk_toggle_gen;
  import clk_toggle_gen_pkg::*;

  typedef struct {
    logic        lvl;   // new clk_out level
    int          len;   // cycles of the phase just ended, 0 = don't care
    logic        stb;
    logic [31:0] cnt;
    logic        run;
  } ev_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  ev_t  exp_q[$];

  clk_toggle_gen_if #(.DIV_W(DIV_W_DEF), .CNT_W(CNT_W_DEF)) bus ();

  clk_toggle_gen #(.DIV_W(DIV_W_DEF), .CNT_W(CNT_W_DEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected counter value: constant 0 when the counter is not built.
  function automatic logic [31:0] ec(input int n);
`ifdef CLK_TOGGLE_GEN_COUNT_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input logic lvl, input int len, input logic stb,
                         input logic [31:0] cnt, input logic run);
    ev_t e;
    e.lvl = lvl; e.len = len; e.stb = stb; e.cnt = cnt; e.run = run;
    exp_q.push_back(e);
  endtask

  // Advance n rising edges, then settle 2 time units past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: sample at the falling edge, well away from the active edge.
  initial begin
    logic prev;
    int   plen;
    ev_t  e;
    prev = 1'b0;
    plen = 0;
    repeat (2) @(negedge clk);
    forever begin
      @(negedge clk);
      check("edge_stb_vs_rise", {31'd0, bus.edge_stb}, {31'd0, (bus.clk_out & ~prev)});
      if (bus.clk_out !== prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_transition: clk_out went to %0b with no expectation (t=%0t)",
                   bus.clk_out, $time);
        end else begin
          e = exp_q.pop_front();
          check("ev_level", {31'd0, bus.clk_out}, {31'd0, e.lvl});
          if (e.len != 0) check("ev_phase_len", plen, e.len);
          check("ev_edge_stb", {31'd0, bus.edge_stb}, {31'd0, e.stb});
          check("ev_edge_cnt", bus.edge_cnt, e.cnt);
          check("ev_running", {31'd0, bus.running}, {31'd0, e.run});
        end
        plen = 1;
      end else begin
        plen++;
      end
      prev = bus.clk_out;
    end
  end

  // Stimulus
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.half_period = 16'd0;

    // Reset state
    tick(3);
    check("rst_clk_out", {31'd0, bus.clk_out}, 32'd0);
    check("rst_running", {31'd0, bus.running}, 32'd0);
    check("rst_edge_stb", {31'd0, bus.edge_stb}, 32'd0);
    check("rst_edge_cnt", bus.edge_cnt, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // half_period=5: ten full periods, then stop from a low phase
    for (int k = 0; k < 10; k++) begin
      push_ev(1'b1, (k == 0) ? 0 : 5, 1'b1, ec(k + 1), 1'b1);
      push_ev(1'b0, 5, 1'b0, ec(k + 1), 1'b1);
    end
    bus.half_period = 16'd5;
    bus.en = 1'b1;
    tick(97);
    bus.en = 1'b0;
    tick(10);
    check("hp5_running_after_stop", {31'd0, bus.running}, 32'd0);
    check("hp5_clk_out_after_stop", {31'd0, bus.clk_out}, 32'd0);
    check("hp5_edge_cnt", bus.edge_cnt, ec(10));

    // half_period=0 behaves as 1: period 2
    push_ev(1'b1, 0, 1'b1, ec(11), 1'b1);
    push_ev(1'b0, 1, 1'b0, ec(11), 1'b1);
    push_ev(1'b1, 1, 1'b1, ec(12), 1'b1);
    push_ev(1'b0, 1, 1'b0, ec(12), 1'b1);
    push_ev(1'b1, 1, 1'b1, ec(13), 1'b1);
    push_ev(1'b0, 1, 1'b0, ec(13), 1'b1);
    bus.half_period = 16'd0;
    bus.en = 1'b1;
    tick(5);
    bus.en = 1'b0;
    tick(4);
    check("hp0_running_after_stop", {31'd0, bus.running}, 32'd0);

    // half_period=4, en dropped 2 cycles into the high phase
    push_ev(1'b1, 0, 1'b1, ec(14), 1'b1);
    push_ev(1'b0, 4, 1'b0, ec(14), 1'b0);
    bus.half_period = 16'd4;
    bus.en = 1'b1;
    tick(2);
    bus.en = 1'b0;
    tick(1);
    check("stop_mid_high_clk_out", {31'd0, bus.clk_out}, 32'd1);
    check("stop_mid_high_running", {31'd0, bus.running}, 32'd1);
    tick(4);
    check("stop_mid_high_idle", {31'd0, bus.running}, 32'd0);

    // half_period=4, en dropped and raised again while stopping
    push_ev(1'b1, 0, 1'b1, ec(15), 1'b1);
    push_ev(1'b0, 4, 1'b0, ec(15), 1'b1);
    push_ev(1'b1, 4, 1'b1, ec(16), 1'b1);
    push_ev(1'b0, 4, 1'b0, ec(16), 1'b1);
    bus.en = 1'b1;
    tick(1);
    bus.en = 1'b0;
    tick(1);
    bus.en = 1'b1;
    tick(10);
    bus.en = 1'b0;
    tick(8);
    check("resume_idle", {31'd0, bus.running}, 32'd0);

    // half_period changed from 3 to 6 during the first high phase
    push_ev(1'b1, 0, 1'b1, ec(17), 1'b1);
    push_ev(1'b0, 3, 1'b0, ec(17), 1'b1);
    push_ev(1'b1, 6, 1'b1, ec(18), 1'b1);
    push_ev(1'b0, 6, 1'b0, ec(18), 1'b0);
    bus.half_period = 16'd3;
    bus.en = 1'b1;
    tick(1);
    bus.half_period = 16'd6;
    tick(10);
    bus.en = 1'b0;
    tick(8);
    check("hp_change_idle", {31'd0, bus.running}, 32'd0);

    // Reset in the middle of a high phase with en held high
    push_ev(1'b1, 0, 1'b1, ec(19), 1'b1);
    push_ev(1'b0, 0, 1'b0, 32'd0, 1'b0);
    push_ev(1'b1, 0, 1'b1, ec(1), 1'b1);
    push_ev(1'b0, 4, 1'b0, ec(1), 1'b0);
    bus.half_period = 16'd4;
    bus.en = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check("midrst_clk_out", {31'd0, bus.clk_out}, 32'd0);
    check("midrst_edge_cnt", bus.edge_cnt, 32'd0);
    check("midrst_running", {31'd0, bus.running}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    bus.en = 1'b0;
    tick(6);
    check("midrst_final_idle", {31'd0, bus.running}, 32'd0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_clk_toggle_gen
